// File: rtl/uart_loader.sv
// uart_loader
// Boot-time program loader for the FlexPRET core. It receives a framed image
// over an 8N1 UART line and writes it, one 32-bit little-endian word at a
// time, into the core's instruction or data memory. The core is held in
// reset while a load is in progress and released by a RUN command.
//
// Frame: 0xA5, cmd, count_lo, count_hi, 4*count data bytes [, checksum]
//   cmd 0x01 load imem, 0x02 load dmem, 0x03 run (no count field)
//
// Optional feature macro: UART_LOADER_CHECKSUM_EN
//   When defined, a load frame carries one trailing XOR checksum byte. A bad
//   checksum sets error and disarms RUN until a load with a good checksum.
//
// Parameters:
//   CLKS_PER_BIT      core clocks per UART bit (minimum 4)
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   uart_rx           asynchronous serial input, idle high
//   io_imem_*         imem word address / write strobe / write data
//   io_dmem_*         dmem word address / access strobe / byte enables / data
//   core_reset        active-high reset to the core (1 out of reset)
//   busy              high from an accepted load command until the frame ends
//   error             sticky error flag, cleared by the next accepted load
module uart_loader #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic [11:0] io_imem_addr,
    output logic        io_imem_write,
    output logic [31:0] io_imem_data_in,
    output logic [11:0] io_dmem_addr,
    output logic        io_dmem_enable,
    output logic        io_dmem_byte_write_3,
    output logic        io_dmem_byte_write_2,
    output logic        io_dmem_byte_write_1,
    output logic        io_dmem_byte_write_0,
    output logic [31:0] io_dmem_data_in,
    output logic        core_reset,
    output logic        busy,
    output logic        error
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [2:0] {
        F_IDLE, F_CMD, F_CNT_LO, F_CNT_HI, F_DATA, F_CHK, F_DONE
    } f_state_t;

`ifdef UART_LOADER_CHECKSUM_EN
    // Running checksum over the data bytes of a frame.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    // ---------------- RX front end ----------------
    logic            rx_meta_r, rx_sync_r;
    rx_state_t       rx_state_r, rx_state_nxt_s;
    logic [CW-1:0]   rx_cnt_r, rx_cnt_nxt_s;
    logic [2:0]      rx_bit_r, rx_bit_nxt_s;
    logic [7:0]      rx_shift_r, rx_shift_nxt_s;
    logic            rx_done_s;
    logic            rx_stop_ok_s;

    // Two-flop synchronizer and RX bit-timing state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            rx_meta_r  <= uart_rx;
            rx_sync_r  <= rx_meta_r;
            rx_state_r <= rx_state_nxt_s;
            rx_cnt_r   <= rx_cnt_nxt_s;
            rx_bit_r   <= rx_bit_nxt_s;
            rx_shift_r <= rx_shift_nxt_s;
        end
    end

    // RX next state: half-bit start recheck, mid-bit data and stop sampling.
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        rx_cnt_nxt_s   = rx_cnt_r;
        rx_bit_nxt_s   = rx_bit_r;
        rx_shift_nxt_s = rx_shift_r;
        rx_done_s      = 1'b0;
        rx_stop_ok_s   = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                rx_cnt_nxt_s = '0;
                rx_bit_nxt_s = 3'd0;
                if (!rx_sync_r) rx_state_nxt_s = RX_START;
                else            rx_state_nxt_s = RX_IDLE;
            end
            RX_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_nxt_s = '0;
                    // A high level at mid start bit is a glitch.
                    if (!rx_sync_r) rx_state_nxt_s = RX_DATA;
                    else            rx_state_nxt_s = RX_IDLE;
                end else begin
                    rx_cnt_nxt_s = rx_cnt_r + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_nxt_s   = '0;
                    rx_shift_nxt_s = {rx_sync_r, rx_shift_r[7:1]};
                    rx_bit_nxt_s   = rx_bit_r + 3'd1;
                    if (rx_bit_r == 3'd7) rx_state_nxt_s = RX_STOP;
                    else                  rx_state_nxt_s = RX_DATA;
                end else begin
                    rx_cnt_nxt_s = rx_cnt_r + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_nxt_s = '0;
                    rx_done_s    = 1'b1;
                    rx_stop_ok_s = rx_sync_r;
                    // After a bad stop bit the line is still low: wait for
                    // idle so the tail of the broken byte is not a new start.
                    if (rx_sync_r) rx_state_nxt_s = RX_IDLE;
                    else           rx_state_nxt_s = RX_WAIT_HIGH;
                end else begin
                    rx_cnt_nxt_s = rx_cnt_r + CW'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_r) rx_state_nxt_s = RX_IDLE;
                else           rx_state_nxt_s = RX_WAIT_HIGH;
            end
            default: begin
                rx_state_nxt_s = RX_IDLE;
            end
        endcase
    end

    // ---------------- Frame FSM ----------------
    f_state_t    f_state_r, f_state_nxt_s;
    logic        sel_dmem_r, sel_dmem_nxt_s;
    logic [15:0] count_r, count_nxt_s;
    logic [12:0] word_idx_r, word_idx_nxt_s;
    logic [1:0]  byte_idx_r, byte_idx_nxt_s;
    logic [23:0] word_r, word_nxt_s;
    logic [11:0] imem_addr_r, imem_addr_nxt_s, dmem_addr_r, dmem_addr_nxt_s;
    logic [31:0] imem_data_r, imem_data_nxt_s, dmem_data_r, dmem_data_nxt_s;
    logic        imem_write_r, imem_write_nxt_s, dmem_en_r, dmem_en_nxt_s;
    logic        core_reset_r, core_reset_nxt_s;
    logic        busy_r, busy_nxt_s, error_r, error_nxt_s;
    logic [15:0] count_full_s;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]  chk_r, chk_nxt_s;
    logic        armed_r, armed_nxt_s;
`endif

    assign count_full_s = {rx_shift_r, count_r[7:0]};

    // Frame FSM state register and registered memory/control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_state_r    <= F_IDLE;
            sel_dmem_r   <= 1'b0;
            count_r      <= 16'h0000;
            word_idx_r   <= 13'd0;
            byte_idx_r   <= 2'd0;
            word_r       <= 24'h000000;
            imem_addr_r  <= 12'h000;
            imem_data_r  <= 32'h0000_0000;
            imem_write_r <= 1'b0;
            dmem_addr_r  <= 12'h000;
            dmem_data_r  <= 32'h0000_0000;
            dmem_en_r    <= 1'b0;
            core_reset_r <= 1'b1;
            busy_r       <= 1'b0;
            error_r      <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            chk_r        <= 8'h00;
            armed_r      <= 1'b1;
`endif
        end else begin
            f_state_r    <= f_state_nxt_s;
            sel_dmem_r   <= sel_dmem_nxt_s;
            count_r      <= count_nxt_s;
            word_idx_r   <= word_idx_nxt_s;
            byte_idx_r   <= byte_idx_nxt_s;
            word_r       <= word_nxt_s;
            imem_addr_r  <= imem_addr_nxt_s;
            imem_data_r  <= imem_data_nxt_s;
            imem_write_r <= imem_write_nxt_s;
            dmem_addr_r  <= dmem_addr_nxt_s;
            dmem_data_r  <= dmem_data_nxt_s;
            dmem_en_r    <= dmem_en_nxt_s;
            core_reset_r <= core_reset_nxt_s;
            busy_r       <= busy_nxt_s;
            error_r      <= error_nxt_s;
`ifdef UART_LOADER_CHECKSUM_EN
            chk_r        <= chk_nxt_s;
            armed_r      <= armed_nxt_s;
`endif
        end
    end

    // Frame decode: acts on each received byte at its stop-bit sample.
    always_comb begin
        f_state_nxt_s    = f_state_r;
        sel_dmem_nxt_s   = sel_dmem_r;
        count_nxt_s      = count_r;
        word_idx_nxt_s   = word_idx_r;
        byte_idx_nxt_s   = byte_idx_r;
        word_nxt_s       = word_r;
        imem_addr_nxt_s  = imem_addr_r;
        imem_data_nxt_s  = imem_data_r;
        imem_write_nxt_s = 1'b0;
        dmem_addr_nxt_s  = dmem_addr_r;
        dmem_data_nxt_s  = dmem_data_r;
        dmem_en_nxt_s    = 1'b0;
        core_reset_nxt_s = core_reset_r;
        busy_nxt_s       = busy_r;
        error_nxt_s      = error_r;
`ifdef UART_LOADER_CHECKSUM_EN
        chk_nxt_s        = chk_r;
        armed_nxt_s      = armed_r;
`endif
        if (rx_done_s && !rx_stop_ok_s) begin
            // Framing error: drop the byte and abandon the frame.
            error_nxt_s   = 1'b1;
            busy_nxt_s    = 1'b0;
            f_state_nxt_s = F_IDLE;
        end else if (f_state_r == F_DONE) begin
            // One cycle after the last strobe.
            busy_nxt_s    = 1'b0;
            f_state_nxt_s = F_IDLE;
        end else if (rx_done_s) begin
            case (f_state_r)
                F_IDLE: begin
                    if (rx_shift_r == 8'hA5) f_state_nxt_s = F_CMD;
                    else                     f_state_nxt_s = F_IDLE;
                end
                F_CMD: begin
                    case (rx_shift_r)
                        8'h01, 8'h02: begin
                            sel_dmem_nxt_s   = (rx_shift_r == 8'h02);
                            core_reset_nxt_s = 1'b1;
                            busy_nxt_s       = 1'b1;
                            error_nxt_s      = 1'b0;
                            f_state_nxt_s    = F_CNT_LO;
                        end
                        8'h03: begin
`ifdef UART_LOADER_CHECKSUM_EN
                            if (armed_r) core_reset_nxt_s = 1'b0;
                            else         error_nxt_s      = 1'b1;
`else
                            core_reset_nxt_s = 1'b0;
`endif
                            f_state_nxt_s = F_IDLE;
                        end
                        default: begin
                            error_nxt_s   = 1'b1;
                            f_state_nxt_s = F_IDLE;
                        end
                    endcase
                end
                F_CNT_LO: begin
                    count_nxt_s   = {8'h00, rx_shift_r};
                    f_state_nxt_s = F_CNT_HI;
                end
                F_CNT_HI: begin
                    count_nxt_s    = count_full_s;
                    word_idx_nxt_s = 13'd0;
                    byte_idx_nxt_s = 2'd0;
`ifdef UART_LOADER_CHECKSUM_EN
                    chk_nxt_s      = 8'h00;
`endif
                    if (count_full_s > 16'd4096) begin
                        error_nxt_s   = 1'b1;
                        busy_nxt_s    = 1'b0;
                        f_state_nxt_s = F_IDLE;
                    end else if (count_full_s == 16'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
                        f_state_nxt_s = F_CHK;
`else
                        busy_nxt_s    = 1'b0;
                        f_state_nxt_s = F_IDLE;
`endif
                    end else begin
                        f_state_nxt_s = F_DATA;
                    end
                end
                F_DATA: begin
`ifdef UART_LOADER_CHECKSUM_EN
                    chk_nxt_s = chk_fold(chk_r, rx_shift_r);
`endif
                    byte_idx_nxt_s = byte_idx_r + 2'd1;
                    case (byte_idx_r)
                        2'd0: word_nxt_s[7:0]   = rx_shift_r;
                        2'd1: word_nxt_s[15:8]  = rx_shift_r;
                        2'd2: word_nxt_s[23:16] = rx_shift_r;
                        2'd3: begin
                            if (sel_dmem_r) begin
                                dmem_addr_nxt_s = word_idx_r[11:0];
                                dmem_data_nxt_s = {rx_shift_r, word_r};
                                dmem_en_nxt_s   = 1'b1;
                            end else begin
                                imem_addr_nxt_s  = word_idx_r[11:0];
                                imem_data_nxt_s  = {rx_shift_r, word_r};
                                imem_write_nxt_s = 1'b1;
                            end
                            word_idx_nxt_s = word_idx_r + 13'd1;
                            if ({3'b000, word_idx_r} + 16'd1 == count_r) begin
`ifdef UART_LOADER_CHECKSUM_EN
                                f_state_nxt_s = F_CHK;
`else
                                f_state_nxt_s = F_DONE;
`endif
                            end else begin
                                f_state_nxt_s = F_DATA;
                            end
                        end
                        default: word_nxt_s = word_r;
                    endcase
                end
`ifdef UART_LOADER_CHECKSUM_EN
                F_CHK: begin
                    if (rx_shift_r == chk_r) begin
                        armed_nxt_s = 1'b1;
                    end else begin
                        armed_nxt_s = 1'b0;
                        error_nxt_s = 1'b1;
                    end
                    busy_nxt_s    = 1'b0;
                    f_state_nxt_s = F_IDLE;
                end
`endif
                default: begin
                    f_state_nxt_s = F_IDLE;
                end
            endcase
        end else begin
            f_state_nxt_s = f_state_r;
        end
    end

    assign io_imem_addr         = imem_addr_r;
    assign io_imem_write        = imem_write_r;
    assign io_imem_data_in      = imem_data_r;
    assign io_dmem_addr         = dmem_addr_r;
    assign io_dmem_enable       = dmem_en_r;
    assign io_dmem_byte_write_3 = dmem_en_r;
    assign io_dmem_byte_write_2 = dmem_en_r;
    assign io_dmem_byte_write_1 = dmem_en_r;
    assign io_dmem_byte_write_0 = dmem_en_r;
    assign io_dmem_data_in      = dmem_data_r;
    assign core_reset           = core_reset_r;
    assign busy                 = busy_r;
    assign error                = error_r;

endmodule

// File: doc/uart_loader.md
# uart_loader

Boot-time program loader sitting directly upstream of the FlexPRET core on the board top level. It receives a framed image over a UART RX line and drives the core's instruction-memory and data-memory write ports, one 32-bit word at a time. It holds the core in reset while loading and releases it on command.

## Interface
- `CLKS_PER_BIT`, 868: core clock cycles per UART bit (100 MHz / 115200); minimum 4.
- `clk`  in  1  core clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `uart_rx`  in  1  asynchronous serial input, 8N1, idle high.
- `io_imem_addr`  out  12  word address into imem.
- `io_imem_write`  out  1  one-cycle imem write strobe.
- `io_imem_data_in`  out  32  imem write data.
- `io_dmem_addr`  out  12  word address into dmem.
- `io_dmem_enable`  out  1  one-cycle dmem access strobe.
- `io_dmem_byte_write_3..0`  out  1 each  byte write enables; all asserted together with `io_dmem_enable`.
- `io_dmem_data_in`  out  32  dmem write data.
- `core_reset`  out  1  active-high reset to core.
- `busy`  out  1  high from accepted command byte until the frame ends.
- `error`  out  1  sticky error flag.

## Operation
- RX front end:
  - 2-flop synchronizer on `uart_rx`.
  - Start bit is re-checked at half-bit; a high sample there is a glitch and returns to idle.
  - Data bits sampled at mid-bit, LSB first.
  - Stop bit sampled at mid-bit. Stop = 0 is a framing error: byte discarded, `error` set, frame FSM to IDLE.
- Frame: `0xA5` sync, cmd, count_lo, count_hi, then 4*count data bytes; each word is little-endian.
- Frame FSM states: IDLE, CMD, CNT_LO, CNT_HI, DATA, (CHK).
  - IDLE: bytes other than `0xA5` are ignored.
  - CMD `0x01`: load imem. CMD `0x02`: load dmem. CMD `0x03`: run; no count field; `core_reset` cleared; back to IDLE.
  - Any other cmd sets `error` and returns to IDLE.
  - An accepted load cmd sets `core_reset`, sets `busy`, and clears `error`.
- Count rules:
  - 16-bit count N, legal range 0..4096.
  - N = 0 ends the frame immediately with no writes.
  - N > 4096 sets `error` and returns to IDLE with no writes.
- Writes:
  - Word k (0-based) is written to address k.
  - Address is 12 bits; word 4096 is never reached, so there is no wrap.
  - Only the selected memory's strobe pulses. The other memory's strobe stays 0, and its address and data hold their previous values.
- Reset mid-operation: FSM to IDLE, byte assembly discarded, all outputs to reset values.

## Timing
- Reset values:
  - All addresses, data and strobes are 0.
  - `busy` = 0, `error` = 0.
  - `core_reset` = 1: the core stays held until the first RUN.
- Write latency:
  - The strobe is asserted the cycle after the 4th byte's stop-bit sample, and lasts exactly 1 cycle.
  - Address and data are valid in the same cycle as the strobe.
- Minimum spacing between strobes is 40 bit times, so no back-pressure is needed; memories accept a write every cycle.
- `busy` falls the cycle after the last strobe, or after the CHK byte when checksum is enabled.
- `core_reset` changes the cycle after the stop-bit sample of the deciding byte.
- Bit-sample jitter is at most 1 cycle (synchronizer); tolerated baud mismatch is ±3%.

## Configuration
- `UART_LOADER_CHECKSUM_EN` defined:
  - A load frame carries one extra byte after the data: the XOR of all data bytes, or of nothing (`0x00`) when N = 0.
  - On mismatch, `error` is set and an `armed` flag is cleared. Writes already performed are not undone.
  - RUN clears `core_reset` only while `armed` = 1. `armed` is set by a load with a matching checksum; its reset value is 1.
  - A RUN refused this way sets `error`.
- Undefined: no CHK state. RUN always releases the core.

## Test plan
- Sync + `0x01` + count `0x0002` + bytes `78 56 34 12 EF BE AD DE` (`CLKS_PER_BIT`=4) -> exactly two one-cycle `io_imem_write` pulses: addr 0 with data `0x12345678`, then addr 1 with data `0xDEADBEEF`. `core_reset` = 1 throughout.
- Same frame with cmd `0x02` -> dmem strobes with all four byte enables high at addr 0 and addr 1. `io_imem_write` stays 0.
- Sequence `0xA5 0x03` -> `core_reset` falls 1 cycle after the stop bit. A following `0xA5 0x01` -> `core_reset` rises again.
- Byte `0x3C` sent with stop bit 0 while in CNT_LO -> `error` = 1, FSM returns to IDLE, no strobes. The next valid load clears `error`.
- Count `0x1001` -> `error` = 1, no writes. Count `0x0000` -> `busy` pulses and no writes occur.
- With `UART_LOADER_CHECKSUM_EN`: a 1-word load with CHK `0x00` where `0x08` is expected -> the word is written, `error` = 1, and a subsequent RUN leaves `core_reset` = 1.
